// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor: unpack/align, signed-magnitude add,
// normalise/round-to-nearest-even. A single global stall freezes every stage under back-pressure.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         out_ovf,
  output logic         out_zero,
  output logic         out_inv
);

  localparam int unsigned MW   = MAN_W + 1;
  localparam int unsigned GW   = MAN_W + 3;
  localparam int unsigned AW   = MAN_W + 4;
  localparam int unsigned SW   = MAN_W + 5;
  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned LZ_W = $clog2(AW + 1);
  localparam logic [EXP_W-1:0]     EMAX   = '1;
  localparam logic signed [XW-1:0] E_INF  = XW'(EMAX);
  localparam logic signed [XW-1:0] E_ZERO = '0;

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb, ml, ms;
  logic             sl, ss, swap;
  logic [2*GW-1:0]  wide, shifted;
  logic [GW-1:0]    s_hi;
  logic             s_st;
  logic             a_nan, b_nan, a_inf, b_inf, sp_inv, sp_inf, sp_inf_sign;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign ma = (ea == '0) ? '0 : {1'b1, fa};
  assign mb = (eb == '0) ? '0 : {1'b1, fb};

  always_comb begin
    swap = {eb, mb} > {ea, ma};
    sl = swap ? sb : sa;
    ss = swap ? sa : sb;
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;
    d  = el - es;
    wide    = {ms, 2'b00, GW'(0)};
    shifted = wide >> d;
    if (32'(d) >= GW) begin
      s_hi = '0;
      s_st = |ms;
    end else begin
      s_hi = shifted[2*GW-1 -: GW];
      s_st = |shifted[GW-1:0];
    end
    a_nan = (ea == EMAX) && (fa != '0);
    b_nan = (eb == EMAX) && (fb != '0);
    a_inf = (ea == EMAX) && (fa == '0);
    b_inf = (eb == EMAX) && (fb == '0);
    sp_inv      = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
    sp_inf      = !sp_inv & (a_inf | b_inf);
    sp_inf_sign = a_inf ? sa : sb;
  end

  logic             s1_valid, s1_sign, s1_sub, s1_inv, s1_inf, s1_inf_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0]    s1_ml, s1_ms;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_inv      <= 1'b0;
      s1_inf      <= 1'b0;
      s1_inf_sign <= 1'b0;
      s1_exp      <= '0;
      s1_ml       <= '0;
      s1_ms       <= '0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_sign     <= sl;
      s1_sub      <= sl ^ ss;
      s1_inv      <= sp_inv;
      s1_inf      <= sp_inf;
      s1_inf_sign <= sp_inf_sign;
      s1_exp      <= el;
      s1_ml       <= {ml, 3'b000};
      s1_ms       <= {s_hi, s_st};
    end
  end

  // ---------------- stage 2: magnitude add/sub (L >= S so never negative) ----------------
  logic [SW-1:0] add_sum;
  logic          add_sign;

  always_comb begin
    add_sum  = s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
    add_sign = (s1_sub && add_sum == '0) ? 1'b0 : s1_sign;
  end

  logic             s2_valid, s2_sign, s2_inv, s2_inf, s2_inf_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_inv      <= 1'b0;
      s2_inf      <= 1'b0;
      s2_inf_sign <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
    end else if (adv) begin
      s2_valid    <= s1_valid;
      s2_sign     <= add_sign;
      s2_inv      <= s1_inv;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= add_sum;
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZ_W-1:0]     lz;
  logic [AW-1:0]       nrm;
  logic [MW-1:0]       mant;
  logic                rnd;
  logic [MAN_W+1:0]    mr;
  logic [MAN_W-1:0]    frac_n;
  logic signed [XW-1:0] e_pre, e_fin;
  logic [W-1:0]        res_n;
  logic                ovf_n, zero_n, inv_n;

  always_comb begin
    lz = '0;
    begin : lzc
      logic found;
      found = 1'b0;
      for (int i = AW - 1; i >= 0; i--) begin
        if (!found) begin
          if (s2_sum[i]) found = 1'b1;
          else           lz = lz + LZ_W'(1);
        end
      end
    end
    if (s2_sum[SW-1]) begin
      nrm    = s2_sum[SW-1:1];
      nrm[0] = s2_sum[1] | s2_sum[0];
      e_pre  = XW'(s2_exp) + XW'(1);
    end else begin
      nrm   = s2_sum[AW-1:0] << lz;
      e_pre = XW'(s2_exp) - XW'(lz);
    end
    mant = nrm[AW-1:3];
    rnd  = nrm[2] & (nrm[1] | nrm[0] | mant[0]);
    mr   = {1'b0, mant} + (MAN_W+2)'(rnd);
    if (mr[MAN_W+1]) begin
      frac_n = mr[MAN_W:1];
      e_fin  = e_pre + XW'(1);
    end else begin
      frac_n = mr[MAN_W-1:0];
      e_fin  = e_pre;
    end

    res_n  = {s2_sign, e_fin[EXP_W-1:0], frac_n};
    ovf_n  = 1'b0;
    zero_n = 1'b0;
    inv_n  = 1'b0;
    if (s2_inv) begin
      res_n = {1'b0, EMAX, 1'b1, (MAN_W-1)'(0)};
      inv_n = 1'b1;
    end else if (s2_inf) begin
      res_n = {s2_inf_sign, EMAX, MAN_W'(0)};
    end else if (s2_sum == '0) begin
      res_n  = {s2_sign, EXP_W'(0), MAN_W'(0)};
      zero_n = 1'b1;
    end else if (e_fin >= E_INF) begin
      res_n = {s2_sign, EMAX, MAN_W'(0)};
      ovf_n = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      res_n  = {s2_sign, EXP_W'(0), MAN_W'(0)};
      zero_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_inv   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result   <= res_n;
        out_ovf  <= ovf_n;
        out_zero <= zero_n;
        out_inv  <= inv_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed single-precision vectors, back-pressure
// stream and mid-flight reset; a monitor pops expected results as the DUT delivers them.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        out_ovf, out_zero, out_inv;

  fp_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_inv(out_inv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // flags are {ovf, zero, inv}
  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sample half a cycle away from the active edge.
  logic [31:0] held = '0;
  bit          stalled = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: result %h appeared with nothing outstanding", result);
        end else if (out_ready) begin
          exp_t e;
          e = q.pop_front();
          check("result", result, e.res);
          check("flags", {29'b0, out_ovf, out_zero, out_inv}, {29'b0, e.flg});
          if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
          stalled = 1'b0;
        end else begin
          check("in_ready_stall", {31'b0, in_ready}, 32'd0);
          check("stall_res", result, q[0].res);
          check("stall_flags", {29'b0, out_ovf, out_zero, out_inv}, {29'b0, q[0].flg});
          if (stalled) check("stall_hold", result, held);
          held    = result;
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                      input logic [31:0] er, input logic [2:0] ef, input bit lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end else begin
      e.res = er; e.flg = ef; e.acc = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (k - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #12;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {29'b0, out_ovf, out_zero, out_inv}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // directed vectors, back-to-back, latency checked on each
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b010, 1'b1);
    send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 1'b1);
    send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000, 1'b1);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 1'b1);
    send(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000, 1'b1);
    send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 1'b1);
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 1'b1);
    send(32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 3'b000, 1'b1);
    send(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 1'b1);
    send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 1'b1);
    send(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b010, 1'b1);
    send(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000, 1'b1);
    idle(3);
    drain();

    // back-pressure: out_ready low from cycle 2 of the stream, released later
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 1'b0);
        send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 3'b000, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(2);
    drain();

    // reset with three operations in flight
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b0);
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b0);
    #1;
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
    check("rst_flush_ready", {31'b0, in_ready}, 32'd1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b1);
    idle(2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor.
- Packed operands go through three stages:
  - unpack/align,
  - signed-magnitude mantissa add/sub,
  - normalise/round.
- Valid/ready handshake on both sides.
- Sits between the operand-select logic and the ALU result mux; delivers one result per cycle when not back-pressured.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (implicit 1 not stored).
- Derived, not overridable: W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- op  input  1  0 = a+b, 1 = a-b.
- a  input  W  operand A {sign, exp, frac}.
- b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  W  packed result.
- out_ovf  output  1  overflow to ±Inf.
- out_zero  output  1  result is ±0, either exact cancellation or underflow flush.
- out_inv  output  1  invalid operation (NaN input or Inf-Inf).

Behaviour:
- Reset (async, rst_n=0):
  - all stage valids = 0; out_valid = 0.
  - result, out_ovf, out_zero, out_inv = 0.
  - in-flight operations are discarded.
  - in_ready is combinational and equals 1 while the pipe is empty.
- Flow control:
  - Global stall: adv = !out_valid | out_ready; in_ready = adv.
  - On adv, every stage shifts one place; a bubble enters when in_valid=0.
  - When adv=0, all stage registers and outputs hold.
  - Latency is 3 cycles from the accepting edge to out_valid. Throughput is 1 per cycle.
  - Results emerge in order; none are dropped or duplicated.
- Stage 1 (unpack/align):
  - eff_sign_b = sign_b ^ op.
  - exp==0 → operand treated as zero (denormals flushed). Otherwise mantissa = {1, frac}, MAN_W+1 bits.
  - Operands are swapped so that L has the larger {exp, mant} and S the smaller.
  - d = exp_L - exp_S. S is shifted right d places into MAN_W+1 bits plus guard, round and sticky; sticky ORs all shifted-out bits.
  - If d ≥ MAN_W+3, S collapses to sticky only.
  - Special inputs (exp all-ones) are classified here:
    - NaN on either input, or Inf and Inf with opposite effective signs → invalid.
    - Otherwise one or both operands are Inf → Inf with sign of the Inf operand.
- Stage 2 (signed-magnitude add):
  - Equal effective signs → sum = L+S, MAN_W+5 bits to include carry; sign = sign_L.
  - Differing signs → L-S, never negative by construction; sign = sign_L.
  - An exact-zero difference forces sign = +.
- Stage 3 (normalise/round):
  - Carry-out set → shift right 1 (sticky absorbs the lost bit), exp+1.
  - Otherwise leading-zero count lz; shift left lz, exp-lz.
  - Round-to-nearest-even on G/R/S. A rounding carry renormalises, shifting right 1 and incrementing exp.
  - Exp ≥ 2^EXP_W-1 → ±Inf (frac=0), out_ovf=1.
  - Exp ≤ 0 or zero mantissa → ±0, out_zero=1.
  - Invalid → canonical NaN: sign 0, exp all-ones, frac MSB set only; out_inv=1.
  - Inf → ±Inf, no flags.
- Flag rules:
  - Flags are valid only with out_valid.
  - At most one flag is set per result.
  - Flags hold with result during a stall.

Test Plan:
1. a=0x3F800000, b=0x40000000, op=0 → result 0x40400000 exactly 3 cycles after acceptance, all flags 0.
2. a=0x3F800000, b=0x3F800000, op=1 → 0x00000000 with out_zero=1. Then a=0x3F800000, b=0x3F7FFFFF, op=1 → 0x33800000, exercising a 24-place left normalisation.
3. Rounding: 0x3F800000+0x33800000 (tie) → 0x3F800000; 0x3F800000+0x33800001 → 0x3F800001.
4. 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, out_ovf=1. 0x7F800000-0x7F800000 (op=1) → 0x7FC00000, out_inv=1.
5. Back-pressure: stream 5 sums back-to-back with out_ready=0 from cycle 2. Required:
   - in_ready drops once out_valid=1;
   - result holds stable while stalled;
   - after out_ready=1, all 5 results appear in order with no loss.
6. Assert rst_n=0 with 3 ops in flight → out_valid drops immediately and no result appears after release. The next op completes normally with 3-cycle latency.
